tri_scan_driver: RTL and testbench
==================================

Name: tri_scan_driver

Overview:
- Front end that feeds the combinational barycentric rasterizer.
- Accepts one triangle (three screen-space vertices plus two depth terms) over a valid/ready handshake.
- Computes the rasterizer's setup operands (anchor vertex, edge deltas, depths) and the screen-clipped bounding box.
- Walks every pixel of the box in raster order, presenting x/y one pixel per cycle under downstream valid/ready; the setup operands are held stable for the whole scan.

Parameters:
- X_LIMIT, 512: screen width; pixel x must be < X_LIMIT.
- Y_LIMIT, 128: screen height; pixel y must be < Y_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tri_valid  in  1  triangle offered
- tri_ready  out  1  block can accept a triangle
- v0x, v1x, v2x  in  9 each  vertex x, unsigned
- v0y, v1y, v2y  in  7 each  vertex y, unsigned
- v1z, v2z  in  7 each  depth terms for vertices 1 and 2
- ax  out  9  anchor x (= v0x)
- ay  out  7  anchor y (= v0y)
- abx  out  8 signed  v1x - v0x
- aby  out  9 signed  v1y - v0y
- bz  out  7  = v1z
- acx  out  8 signed  v2x - v0x
- acy  out  9 signed  v2y - v0y
- cz  out  7  = v2z
- pix_valid  out  1  x/y valid
- pix_ready  in  1  downstream accepts pixel
- x  out  10  pixel x
- y  out  10  pixel y
- pix_last  out  1  current pixel is the final pixel of the triangle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: triangle finished (scanned or empty)
- reject  out  1  one-cycle pulse: triangle dropped, x-delta out of range

Behaviour:
- Reset (async, rst_n low): state IDLE; all setup outputs, x, y = 0; pix_valid, pix_last, done, reject, busy = 0; tri_ready = 1 once rst_n releases. Reset mid-scan abandons the triangle with no done pulse.
- States: IDLE, SETUP, SCAN.
- IDLE:
  - tri_ready = 1.
  - On tri_valid && tri_ready: latch all vertex inputs and go to SETUP.
- SETUP (exactly 1 cycle, tri_ready = 0):
  - Compute dxb = v1x - v0x and dxc = v2x - v0x at 10-bit signed width.
  - If either lies outside [-128, 127]: pulse reject, go to IDLE; no pixels, no done.
  - Otherwise register ax, ay, abx, aby, bz, acx, acy, cz. The y deltas always fit in 9 bits signed.
  - Bounding box: xmin/xmax = min/max of vertex x; ymin/ymax likewise; then xmax = min(xmax, X_LIMIT-1), ymax = min(ymax, Y_LIMIT-1).
  - If xmin > xmax or ymin > ymax: pulse done, go to IDLE.
  - Otherwise set x = xmin, y = ymin and go to SCAN.
- SCAN:
  - pix_valid = 1. x and y change only on a handshake (pix_valid && pix_ready); with pix_ready low, x, y and pix_last hold.
  - On a handshake with x < xmax: x <= x + 1.
  - On a handshake with x == xmax and y < ymax: x <= xmin, y <= y + 1.
  - On a handshake with x == xmax and y == ymax: go to IDLE, pix_valid low next cycle, done pulses that same cycle.
  - pix_last = (x == xmax && y == ymax) while pix_valid.
- Degenerate (zero-area) triangles are scanned normally; the rasterizer's visible output masks them.
- Setup outputs stay stable from SETUP exit until the next triangle is accepted. They are not cleared on done.
- Latency:
  - Triangle accepted at cycle T; first pix_valid at T+2.
  - Throughput is 1 pixel/cycle with pix_ready held high.
  - Final handshake at cycle F: done at F+1, tri_ready high at F+1, next triangle accepted no earlier than F+1.
- No overlap between triangles; tri_valid is ignored while busy.
- done and reject are mutually exclusive and never both asserted.

Test Plan:
- Vertices (10,5),(12,5),(10,7), pix_ready=1 -> abx=2, aby=0, acx=0, acy=2. Nine pixels in order (10,5),(11,5),(12,5),(10,6)…(12,7); first pix_valid at T+2; pix_last only on (12,7); done 1 cycle after.
- Same triangle, pix_ready toggled 1,0,0,1,… -> x/y hold during stalls; same 9-pixel sequence, no duplicates or skips.
- Vertices (0,0),(200,0),(0,10) -> reject pulse at T+1, zero pixels, no done, tri_ready high at T+2.
- X_LIMIT=16, vertices (14,3),(20,3),(14,4) -> xmax clipped to 15; pixels (14,3),(15,3),(14,4),(15,4); X_LIMIT=16 with all x ≥ 16 -> done, no pixels.
- Single-point triangle (7,7)×3 -> exactly one pixel (7,7) with pix_last=1, then done.
- rst_n low mid-scan -> all outputs 0 immediately, no done; after release a new triangle scans correctly from its own xmin/ymin.

Source files
------------

// File: rtl/tri_scan_driver_if.sv
// Triangle-in / setup-operand / pixel-out bundle between the scan driver (slave) and its environment (master).
interface tri_scan_driver_if;
  logic              tri_valid;
  logic              tri_ready;
  logic [8:0]        v0x, v1x, v2x;
  logic [6:0]        v0y, v1y, v2y;
  logic [6:0]        v1z, v2z;

  logic [8:0]        ax;
  logic [6:0]        ay;
  logic signed [7:0] abx;
  logic signed [8:0] aby;
  logic [6:0]        bz;
  logic signed [7:0] acx;
  logic signed [8:0] acy;
  logic [6:0]        cz;

  logic              pix_valid;
  logic              pix_ready;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              pix_last;

  modport master (
    output tri_valid, v0x, v1x, v2x, v0y, v1y, v2y, v1z, v2z, pix_ready,
    input  tri_ready, ax, ay, abx, aby, bz, acx, acy, cz, pix_valid, x, y, pix_last
  );

  modport slave (
    input  tri_valid, v0x, v1x, v2x, v0y, v1y, v2y, v1z, v2z, pix_ready,
    output tri_ready, ax, ay, abx, aby, bz, acx, acy, cz, pix_valid, x, y, pix_last
  );
endinterface

// File: rtl/tri_scan_driver.sv
// Rasterizer front end: latches a triangle, derives setup operands and a screen-clipped box, walks it in raster order.
// First pixel 2 cycles after accept; pix_ready low freezes x/y/pix_last; no new triangle is taken while busy.
module tri_scan_driver #(
  parameter int X_LIMIT = 512,
  parameter int Y_LIMIT = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  tri_scan_driver_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             reject
);
  localparam logic [9:0] X_MAX_CLIP = 10'(X_LIMIT - 1);
  localparam logic [9:0] Y_MAX_CLIP = 10'(Y_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
  state_t state_q, state_d;

  logic [8:0]        v0x_q, v1x_q, v2x_q;
  logic [6:0]        v0y_q, v1y_q, v2y_q;
  logic [6:0]        v1z_q, v2z_q;

  logic [8:0]        ax_q;
  logic [6:0]        ay_q, bz_q, cz_q;
  logic signed [7:0] abx_q, acx_q;
  logic signed [8:0] aby_q, acy_q;

  logic [9:0]        x_q, y_q;
  logic [9:0]        xmin_q, xmax_q, ymax_q;
  logic              done_q;

  logic              tri_ready_c, pix_valid_c, reject_c, empty_done;
  logic              accept, pix_hs, x_at_end, y_at_end, at_last;
  logic              setup_go, scan_go;

  logic signed [9:0] dxb, dxc;
  logic signed [8:0] dyb, dyc;
  logic              dx_ok;
  logic [9:0]        xmin_c, xmax_raw, xmax_c;
  logic [9:0]        ymin_c, ymax_raw, ymax_c;
  logic              box_empty;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign dxb = $signed({1'b0, v1x_q}) - $signed({1'b0, v0x_q});
  assign dxc = $signed({1'b0, v2x_q}) - $signed({1'b0, v0x_q});
  assign dyb = $signed({2'b00, v1y_q}) - $signed({2'b00, v0y_q});
  assign dyc = $signed({2'b00, v2y_q}) - $signed({2'b00, v0y_q});

  // An x delta is usable only if it sign-extends cleanly from the 8-bit operand width.
  assign dx_ok = ((dxb[9:7] == 3'b000) || (dxb[9:7] == 3'b111)) &&
                 ((dxc[9:7] == 3'b000) || (dxc[9:7] == 3'b111));

  assign xmin_c   = min3({1'b0, v0x_q}, {1'b0, v1x_q}, {1'b0, v2x_q});
  assign xmax_raw = max3({1'b0, v0x_q}, {1'b0, v1x_q}, {1'b0, v2x_q});
  assign xmax_c   = (xmax_raw > X_MAX_CLIP) ? X_MAX_CLIP : xmax_raw;
  assign ymin_c   = min3({3'b000, v0y_q}, {3'b000, v1y_q}, {3'b000, v2y_q});
  assign ymax_raw = max3({3'b000, v0y_q}, {3'b000, v1y_q}, {3'b000, v2y_q});
  assign ymax_c   = (ymax_raw > Y_MAX_CLIP) ? Y_MAX_CLIP : ymax_raw;
  assign box_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);

  assign x_at_end = (x_q == xmax_q);
  assign y_at_end = (y_q == ymax_q);
  assign at_last  = x_at_end && y_at_end;
  assign accept   = tri_ready_c && bus.tri_valid;
  assign pix_hs   = pix_valid_c && bus.pix_ready;
  assign setup_go = (state_q == SETUP) && dx_ok;
  assign scan_go  = setup_go && !box_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tri_ready_c = 1'b0;
    pix_valid_c = 1'b0;
    reject_c    = 1'b0;
    empty_done  = 1'b0;
    case (state_q)
      IDLE: begin
        tri_ready_c = rst_n;
        if (bus.tri_valid && rst_n) state_d = SETUP;
      end
      SETUP: begin
        if (!dx_ok) begin
          reject_c = 1'b1;
          state_d  = IDLE;
        end else if (box_empty) begin
          empty_done = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        pix_valid_c = 1'b1;
        if (bus.pix_ready && at_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0x_q  <= '0;
      v1x_q  <= '0;
      v2x_q  <= '0;
      v0y_q  <= '0;
      v1y_q  <= '0;
      v2y_q  <= '0;
      v1z_q  <= '0;
      v2z_q  <= '0;
      ax_q   <= '0;
      ay_q   <= '0;
      abx_q  <= '0;
      aby_q  <= '0;
      bz_q   <= '0;
      acx_q  <= '0;
      acy_q  <= '0;
      cz_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        v0x_q <= bus.v0x;
        v1x_q <= bus.v1x;
        v2x_q <= bus.v2x;
        v0y_q <= bus.v0y;
        v1y_q <= bus.v1y;
        v2y_q <= bus.v2y;
        v1z_q <= bus.v1z;
        v2z_q <= bus.v2z;
      end
      // Setup operands are published even for an empty box; a rejected triangle leaves the previous set.
      if (setup_go) begin
        ax_q  <= v0x_q;
        ay_q  <= v0y_q;
        abx_q <= dxb[7:0];
        aby_q <= dyb;
        bz_q  <= v1z_q;
        acx_q <= dxc[7:0];
        acy_q <= dyc;
        cz_q  <= v2z_q;
      end
      if (scan_go) begin
        xmin_q <= xmin_c;
        xmax_q <= xmax_c;
        ymax_q <= ymax_c;
        x_q    <= xmin_c;
        y_q    <= ymin_c;
      end
      if (pix_hs) begin
        if (x_q < xmax_q) begin
          x_q <= x_q + 10'd1;
        end else if (y_q < ymax_q) begin
          x_q <= xmin_q;
          y_q <= y_q + 10'd1;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.tri_ready = tri_ready_c;
  assign bus.ax        = ax_q;
  assign bus.ay        = ay_q;
  assign bus.abx       = abx_q;
  assign bus.aby       = aby_q;
  assign bus.bz        = bz_q;
  assign bus.acx       = acx_q;
  assign bus.acy       = acy_q;
  assign bus.cz        = cz_q;
  assign bus.pix_valid = pix_valid_c;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.pix_last  = pix_valid_c && at_last;

  assign busy   = (state_q != IDLE);
  assign done   = done_q || empty_done;
  assign reject = reject_c;
endmodule

// File: tb/tb_tri_scan_driver.sv
// Scoreboard bench for tri_scan_driver: a default-screen instance and a 16-pixel-wide instance for clipping.
module tb_tri_scan_driver;
  logic clk;
  logic rst_n;
  logic busy0, done0, reject0;
  logic busy1, done1, reject1;

  tri_scan_driver_if bus0();
  tri_scan_driver_if bus1();

  tri_scan_driver #(.X_LIMIT(512), .Y_LIMIT(128)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0), .done(done0), .reject(reject0)
  );

  tri_scan_driver #(.X_LIMIT(16), .Y_LIMIT(128)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .done(done1), .reject(reject1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       last;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks;
  int   n_fails;
  bit   sel;

  logic       s_tri_ready, s_pix_valid, s_pix_last, s_busy, s_done, s_reject;
  logic [8:0] s_ax, s_aby, s_acy;
  logic [6:0] s_ay, s_bz, s_cz;
  logic [7:0] s_abx, s_acx;
  logic [9:0] s_x, s_y;

  assign s_tri_ready = sel ? bus1.tri_ready : bus0.tri_ready;
  assign s_pix_valid = sel ? bus1.pix_valid : bus0.pix_valid;
  assign s_pix_last  = sel ? bus1.pix_last  : bus0.pix_last;
  assign s_busy      = sel ? busy1          : busy0;
  assign s_done      = sel ? done1          : done0;
  assign s_reject    = sel ? reject1        : reject0;
  assign s_ax        = sel ? bus1.ax        : bus0.ax;
  assign s_ay        = sel ? bus1.ay        : bus0.ay;
  assign s_abx       = sel ? bus1.abx       : bus0.abx;
  assign s_aby       = sel ? bus1.aby       : bus0.aby;
  assign s_bz        = sel ? bus1.bz        : bus0.bz;
  assign s_acx       = sel ? bus1.acx       : bus0.acx;
  assign s_acy       = sel ? bus1.acy       : bus0.acy;
  assign s_cz        = sel ? bus1.cz        : bus0.cz;
  assign s_x         = sel ? bus1.x         : bus0.x;
  assign s_y         = sel ? bus1.y         : bus0.y;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_tri(input bit s, input bit vld, input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2, input int z1, input int z2);
    if (s) begin
      bus1.tri_valid = vld;
      bus1.v0x = 9'(x0); bus1.v1x = 9'(x1); bus1.v2x = 9'(x2);
      bus1.v0y = 7'(y0); bus1.v1y = 7'(y1); bus1.v2y = 7'(y2);
      bus1.v1z = 7'(z1); bus1.v2z = 7'(z2);
    end else begin
      bus0.tri_valid = vld;
      bus0.v0x = 9'(x0); bus0.v1x = 9'(x1); bus0.v2x = 9'(x2);
      bus0.v0y = 7'(y0); bus0.v1y = 7'(y1); bus0.v2y = 7'(y2);
      bus0.v1z = 7'(z1); bus0.v2z = 7'(z2);
    end
  endtask

  task automatic drive_rdy(input bit s, input bit r);
    if (s) bus1.pix_ready = r;
    else   bus0.pix_ready = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: pix_ready held high; mode 1: pix_ready pattern 1,0,0 repeating
  task automatic run_tri(input string name, input bit s, input int x0, input int y0, input int x1,
                         input int y1, input int x2, input int y2, input int z1, input int z2,
                         input int mode);
    int xlim, xmin, xmax, ymin, ymax, dxb, dxc, dyb, dyc, k, budget;
    bit rej, empty, fin, stalled, rdy;
    logic [9:0] px, py;
    pix_t e;

    xlim = s ? 16 : 512;
    dxb = x1 - x0; dxc = x2 - x0; dyb = y1 - y0; dyc = y2 - y0;
    rej = (dxb < -128) || (dxb > 127) || (dxc < -128) || (dxc > 127);
    xmin = x0; if (x1 < xmin) xmin = x1; if (x2 < xmin) xmin = x2;
    xmax = x0; if (x1 > xmax) xmax = x1; if (x2 > xmax) xmax = x2;
    ymin = y0; if (y1 < ymin) ymin = y1; if (y2 < ymin) ymin = y2;
    ymax = y0; if (y1 > ymax) ymax = y1; if (y2 > ymax) ymax = y2;
    if (xmax > xlim - 1) xmax = xlim - 1;
    if (ymax > 127) ymax = 127;
    empty = !rej && ((xmin > xmax) || (ymin > ymax));
    if (!rej && !empty) begin
      for (int yy = ymin; yy <= ymax; yy++) begin
        for (int xx = xmin; xx <= xmax; xx++) begin
          e.x = 10'(xx);
          e.y = 10'(yy);
          e.last = (xx == xmax) && (yy == ymax);
          exp_q.push_back(e);
        end
      end
    end
    budget = 3 * exp_q.size() + 20;

    sel = s;
    #0;
    drive_tri(s, 1'b1, x0, y0, x1, y1, x2, y2, z1, z2);
    check_val({name, ":tri_ready_T"}, s_tri_ready, 1);
    next_cycle();
    drive_tri(s, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val({name, ":reject_T1"}, s_reject, rej);
    check_val({name, ":done_T1"}, s_done, empty);
    check_val({name, ":busy_T1"}, s_busy, 1);
    check_val({name, ":tri_ready_T1"}, s_tri_ready, 0);
    check_val({name, ":pix_valid_T1"}, s_pix_valid, 0);
    next_cycle();
    check_val({name, ":tri_ready_T2"}, s_tri_ready, rej || empty);
    check_val({name, ":done_T2"}, s_done, 0);
    check_val({name, ":reject_T2"}, s_reject, 0);
    check_val({name, ":pix_valid_T2"}, s_pix_valid, !rej && !empty);
    if (!rej) begin
      check_val({name, ":ax"}, s_ax, x0);
      check_val({name, ":ay"}, s_ay, y0);
      check_val({name, ":abx"}, s_abx, dxb & 255);
      check_val({name, ":aby"}, s_aby, dyb & 511);
      check_val({name, ":bz"}, s_bz, z1);
      check_val({name, ":acx"}, s_acx, dxc & 255);
      check_val({name, ":acy"}, s_acy, dyc & 511);
      check_val({name, ":cz"}, s_cz, z2);
    end

    if (!rej && !empty) begin
      k = 0; fin = 0; stalled = 0; px = '0; py = '0;
      while (!fin && k < budget) begin
        rdy = (mode == 0) ? 1'b1 : ((k % 3) == 0);
        drive_rdy(s, rdy);
        #0;
        if (stalled) begin
          check_val({name, ":hold_x"}, s_x, px);
          check_val({name, ":hold_y"}, s_y, py);
        end
        if (s_pix_valid && rdy) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = '1;
          check_val({name, ":pix_x"}, s_x, e.x);
          check_val({name, ":pix_y"}, s_y, e.y);
          check_val({name, ":pix_last"}, s_pix_last, e.last);
          check_val({name, ":no_done_mid"}, s_done, 0);
          fin = (exp_q.size() == 0);
          stalled = 0;
        end else begin
          stalled = s_pix_valid;
          px = s_x;
          py = s_y;
        end
        next_cycle();
        k++;
      end
      drive_rdy(s, 1'b0);
      check_val({name, ":scan_finished"}, fin, 1);
      check_val({name, ":done_after_last"}, s_done, 1);
      check_val({name, ":pix_valid_after_last"}, s_pix_valid, 0);
      check_val({name, ":tri_ready_after_last"}, s_tri_ready, 1);
      next_cycle();
      check_val({name, ":done_one_cycle"}, s_done, 0);
    end
    check_val({name, ":queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int rx0, ry0, rx1, ry1, rx2, ry2;
    n_checks = 0;
    n_fails  = 0;
    sel = 0;
    rst_n = 1'b0;
    drive_tri(0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_tri(1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_rdy(0, 1'b0);
    drive_rdy(1, 1'b0);
    #1;
    check_val("rst:tri_ready", s_tri_ready, 0);
    check_val("rst:pix_valid", s_pix_valid, 0);
    check_val("rst:busy", s_busy, 0);
    check_val("rst:x", s_x, 0);
    check_val("rst:ax", s_ax, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    next_cycle();
    check_val("post_rst:tri_ready", s_tri_ready, 1);
    check_val("post_rst:done", s_done, 0);

    run_tri("basic", 0, 10, 5, 12, 5, 10, 7, 3, 9, 0);
    run_tri("stall", 0, 10, 5, 12, 5, 10, 7, 3, 9, 1);
    run_tri("reject200", 0, 0, 0, 200, 0, 0, 10, 1, 2, 0);
    run_tri("reject_neg", 0, 300, 0, 300, 0, 100, 5, 1, 2, 0);
    run_tri("reject128", 0, 0, 0, 128, 0, 0, 0, 1, 2, 0);
    run_tri("edge_m128", 0, 200, 0, 72, 0, 200, 1, 5, 6, 0);
    run_tri("edge_p127", 0, 10, 3, 137, 3, 10, 3, 0, 0, 1);
    run_tri("clip16", 1, 14, 3, 20, 3, 14, 4, 7, 8, 0);
    run_tri("offscreen16", 1, 16, 1, 18, 1, 16, 2, 7, 8, 0);
    run_tri("point", 0, 7, 7, 7, 7, 7, 7, 4, 4, 0);

    for (int i = 0; i < 4; i++) begin
      rx0 = $urandom_range(10, 500);
      ry0 = $urandom_range(4, 123);
      rx1 = rx0 + $urandom_range(0, 12) - 6;
      rx2 = rx0 + $urandom_range(0, 12) - 6;
      ry1 = ry0 + $urandom_range(0, 6) - 3;
      ry2 = ry0 + $urandom_range(0, 6) - 3;
      run_tri("random", 0, rx0, ry0, rx1, ry1, rx2, ry2, $urandom_range(0, 127),
              $urandom_range(0, 127), i % 2);
    end

    // Reset in the middle of a scan: everything clears at once and no done follows.
    sel = 0;
    drive_tri(0, 1'b1, 100, 20, 110, 20, 100, 24, 3, 4);
    next_cycle();
    drive_tri(0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive_rdy(0, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst:pix_valid", s_pix_valid, 0);
    check_val("midrst:x", s_x, 0);
    check_val("midrst:y", s_y, 0);
    check_val("midrst:ax", s_ax, 0);
    check_val("midrst:abx", s_abx, 0);
    check_val("midrst:busy", s_busy, 0);
    check_val("midrst:pix_last", s_pix_last, 0);
    check_val("midrst:done", s_done, 0);
    drive_rdy(0, 1'b0);
    next_cycle();
    #2 rst_n = 1'b1;
    next_cycle();
    check_val("midrst_rel:done", s_done, 0);
    check_val("midrst_rel:busy", s_busy, 0);
    check_val("midrst_rel:tri_ready", s_tri_ready, 1);
    run_tri("after_rst", 0, 30, 40, 33, 40, 30, 41, 2, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
